// File: rtl/alu_mc_if.sv
// Handshake and operand/result bus between an ALU client and alu_mc.
interface alu_mc_if #(
   parameter int XLEN = 32
);
   logic            kill;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out;
   logic            err;

   modport master (
      output kill, in_valid, opcode, funct3, funct7, in1, in2, out_ready,
      input  in_ready, out_valid, out, err
   );

   modport slave (
      input  kill, in_valid, opcode, funct3, funct7, in1, in2, out_ready,
      output in_ready, out_valid, out, err
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle RV integer ALU: single-cycle base ops, iterative shift-add
// multiply and restoring divide taking XLEN cycles each.
module alu_mc #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic    clk,
   input  logic    rst_n,
   alu_mc_if.slave bus
);
   localparam logic [4:0] OP_R    = 5'b01100;
   localparam logic [4:0] OP_I    = 5'b00100;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;
   // RV64 shift immediates carry shamt[5] in funct7[0]
   localparam logic [6:0] F7_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   out_q, out_d;
   logic              err_q, err_d;
   logic              out_valid_q, out_valid_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   // MUL: acc = partial product, mcand = shifted multiplicand, mplier = multiplier
   // DIV: acc = partial remainder, mcand = divisor, mplier = dividend/quotient
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [2:0]        f3_q, f3_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;

   logic              in_ready;
   logic              accept;

   assign in_ready      = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && in_ready && !bus.kill;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.err       = err_q;

   logic [XLEN-1:0] base_res;
   logic            base_ill;
   logic            alt;
   logic [SHW-1:0]  shamt;
   logic [6:0]      f7m;

   always_comb begin
      shamt    = bus.in2[SHW-1:0];
      f7m      = bus.funct7 & F7_MASK;
      base_res = '0;
      base_ill = 1'b0;
      alt      = 1'b0;
      if (bus.opcode == OP_R) begin
         alt      = (bus.funct7 == F7_ALT);
         base_ill = !((bus.funct7 == F7_BASE) ||
                      (alt && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101)));
      end else if (bus.opcode == OP_I) begin
         alt = (f7m == F7_ALT) && (bus.funct3 == 3'b101);
         if (bus.funct3 == 3'b001)
            base_ill = (f7m != F7_BASE);
         else if (bus.funct3 == 3'b101)
            base_ill = !((f7m == F7_BASE) || (f7m == F7_ALT));
      end else begin
         base_ill = 1'b1;
      end
      case (bus.funct3)
         3'b000:  base_res = alt ? (bus.in1 - bus.in2) : (bus.in1 + bus.in2);
         3'b001:  base_res = bus.in1 << shamt;
         3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
         3'b011:  base_res = {{(XLEN-1){1'b0}}, bus.in1 < bus.in2};
         3'b100:  base_res = bus.in1 ^ bus.in2;
         3'b101:  base_res = alt ? XLEN'($signed(bus.in1) >>> shamt) : (bus.in1 >> shamt);
         3'b110:  base_res = bus.in1 | bus.in2;
         default: base_res = bus.in1 & bus.in2;
      endcase
      if (base_ill)
         base_res = '0;
   end

   logic              is_m;
   logic              sgn1, sgn2, a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [2*XLEN-1:0] acc_sum, prod;
   logic [XLEN:0]     div_r, div_t;
   logic              div_ok;
   logic [XLEN-1:0]   rem_n, quo_n, quo_f, rem_f;

   always_comb begin
      is_m   = (bus.opcode == OP_R) && (bus.funct7 == F7_M);
      sgn1   = bus.funct3[2] ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
      sgn2   = bus.funct3[2] ? !bus.funct3[0] : !bus.funct3[1];
      a_neg  = sgn1 && bus.in1[XLEN-1];
      b_neg  = sgn2 && bus.in2[XLEN-1];
      mag_a  = a_neg ? -bus.in1 : bus.in1;
      mag_b  = b_neg ? -bus.in2 : bus.in2;

      acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod    = negq_q ? -acc_sum : acc_sum;

      div_r  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
      div_t  = div_r - {1'b0, mcand_q[XLEN-1:0]};
      div_ok = !div_t[XLEN];
      rem_n  = div_ok ? div_t[XLEN-1:0] : div_r[XLEN-1:0];
      quo_n  = {mplier_q[XLEN-2:0], div_ok};
      quo_f  = negq_q ? -quo_n : quo_n;
      rem_f  = negr_q ? -rem_n : rem_n;
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      f3_d        = f3_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      case (state_q)
         S_IDLE: begin
            if (out_valid_q && bus.out_ready)
               out_valid_d = 1'b0;
            if (accept) begin
               f3_d  = bus.funct3;
               err_d = 1'b0;
               cnt_d = '0;
               if (is_m && !bus.funct3[2]) begin
                  state_d  = S_MUL;
                  acc_d    = '0;
                  mcand_d  = {{XLEN{1'b0}}, mag_a};
                  mplier_d = mag_b;
                  negq_d   = a_neg ^ b_neg;
               end else if (is_m && bus.in2 == '0) begin
                  out_d       = bus.funct3[1] ? bus.in1 : '1;
                  out_valid_d = 1'b1;
               end else if (is_m && sgn1 && bus.in1 == MIN_VAL && bus.in2 == '1) begin
                  out_d       = bus.funct3[1] ? '0 : bus.in1;
                  out_valid_d = 1'b1;
               end else if (is_m) begin
                  state_d  = S_DIV;
                  acc_d    = '0;
                  mcand_d  = {{XLEN{1'b0}}, mag_b};
                  mplier_d = mag_a;
                  negq_d   = a_neg ^ b_neg;
                  negr_d   = a_neg;
               end else begin
                  out_d       = base_res;
                  err_d       = base_ill;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(XLEN-1)) begin
               out_d       = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
               cnt_d       = '0;
            end
         end
         S_DIV: begin
            acc_d    = {{XLEN{1'b0}}, rem_n};
            mplier_d = quo_n;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(XLEN-1)) begin
               out_d       = f3_q[1] ? rem_f : quo_f;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
               cnt_d       = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // kill wins over everything, including an offer in the same cycle
      if (bus.kill) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         f3_q        <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         f3_q        <= f3_d;
         negq_q      <= negq_d;
         negr_q      <= negr_d;
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// Randomized bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
   localparam int XLEN = 32;
   localparam logic [4:0] OPR = 5'b01100;
   localparam logic [4:0] OPI = 5'b00100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   alu_mc_if #(.XLEN(XLEN)) bus();
   alu_mc #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Reference: {err, result} from the ISA rules using native arithmetic
   function automatic logic [XLEN:0] ref_op(input logic [4:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic [63:0] up;
      logic [31:0] r;
      logic e;
      sa = $signed(a);
      sb = $signed(b);
      ub = {32'b0, b};
      up = {32'b0, a} * {32'b0, b};
      r = 32'h0;
      e = 1'b0;
      if (opc == OPR && f7 == 7'h01) begin
         case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: r = up[63:32];
            3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
         endcase
      end else if (opc == OPR && f7 == 7'h20 && f3 == 3'd0) r = a - b;
      else if (opc == OPR && f7 == 7'h20 && f3 == 3'd5) r = 32'(sa >>> b[4:0]);
      else if ((opc == OPR && f7 == 7'h00) || opc == OPI) begin
         case (f3)
            3'd0: r = a + b;
            3'd1: if (opc == OPI && f7 != 7'h00) e = 1'b1; else r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (f7 == 7'h20) r = 32'(sa >>> b[4:0]);
                  else if (f7 == 7'h00) r = a >> b[4:0];
                  else e = 1'b1;
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end else e = 1'b1;
      if (e) r = 32'h0;
      return {e, r};
   endfunction

   function automatic int ref_lat(input logic [4:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      if (!(opc == OPR && f7 == 7'h01)) return 1;
      if (!f3[2]) return XLEN + 1;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic offer(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic ordy, output logic rdy);
      @(negedge clk);
      bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7;
      bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1; bus.out_ready = ordy;
      #1 rdy = bus.in_ready;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in1 = $urandom; bus.in2 = $urandom;
      bus.opcode = 5'($urandom); bus.funct3 = 3'($urandom); bus.funct7 = 7'($urandom);
   endtask

   task automatic wait_result(output int lat, output logic [31:0] o, output logic e, output logic busy_ok);
      lat = -1; o = 32'h0; e = 1'b0; busy_ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = i; o = bus.out; e = bus.err;
            break;
         end
         if (bus.in_ready) busy_ok = 1'b0;
      end
   endtask

   task automatic issue(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic rdy, output int lat, output logic [31:0] o, output logic e, output logic busy_ok);
      offer(opc, f3, f7, a, b, 1'b1, rdy);
      wait_result(lat, o, e, busy_ok);
      $display("txn op=%b f3=%0d f7=%h a=%h b=%h out=%h err=%0d lat=%0d", opc, f3, f7, a, b, o, e, lat);
   endtask

   task automatic test_reset();
      bus.kill = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0; bus.in1 = '0; bus.in2 = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      logic rdy, e, busy; int lat; logic [31:0] o;
      issue(OPR, 3'd0, 7'h00, 32'hFFFFFFFF, 32'h1, rdy, lat, o, e, busy);
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL first_accept in_ready got=%b exp=1", rdy); end
      total++; if ({lat, o, e} !== {32'd1, 32'h0, 1'b0}) begin bad++; $display("FAIL add_wrap got lat=%0d out=%h err=%b exp lat=1 out=0 err=0", lat, o, e); end
      issue(OPR, 3'd5, 7'h20, 32'h80000000, 32'h24, rdy, lat, o, e, busy);
      total++; if ({lat, o} !== {32'd1, 32'hF8000000}) begin bad++; $display("FAIL sra got lat=%0d out=%h exp lat=1 out=f8000000", lat, o); end
      issue(OPR, 3'd1, 7'h01, 32'h80000000, 32'h80000000, rdy, lat, o, e, busy);
      total++; if ({lat, o} !== {32'd33, 32'h40000000}) begin bad++; $display("FAIL mulh got lat=%0d out=%h exp lat=33 out=40000000", lat, o); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mulh_busy in_ready_low got=%b exp=1", busy); end
      issue(OPR, 3'd4, 7'h01, 32'd7, 32'd0, rdy, lat, o, e, busy);
      total++; if ({lat, o} !== {32'd1, 32'hFFFFFFFF}) begin bad++; $display("FAIL div0 got lat=%0d out=%h exp lat=1 out=ffffffff", lat, o); end
      issue(OPR, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, rdy, lat, o, e, busy);
      total++; if ({lat, o} !== {32'd1, 32'h0}) begin bad++; $display("FAIL rem_ovf got lat=%0d out=%h exp lat=1 out=0", lat, o); end
   endtask

   task automatic test_illegal();
      logic [4:0] opc [4] = '{OPR, OPI, 5'b11111, OPR};
      logic [2:0] f3  [4] = '{3'd1, 3'd1, 3'd0, 3'd4};
      logic [6:0] f7  [4] = '{7'h20, 7'h20, 7'h00, 7'h7F};
      logic rdy, e, busy; int lat; logic [31:0] o;
      for (int i = 0; i < 4; i++) begin
         issue(opc[i], f3[i], f7[i], pick(), pick(), rdy, lat, o, e, busy);
         total++; if ({lat, o, e} !== {32'd1, 32'h0, 1'b1}) begin bad++; $display("FAIL illegal%0d got lat=%0d out=%h err=%b exp lat=1 out=0 err=1", i, lat, o, e); end
      end
   endtask

   task automatic test_random_base();
      logic rdy, e, busy; int lat; logic [31:0] o, a, b; logic [4:0] opc; logic [2:0] f3; logic [6:0] f7; logic [XLEN:0] x;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            opc = OPR;
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
         end else begin
            opc = OPI;
            f7 = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : (f3 == 3'd1 || f3 == 3'd5) ? 7'h00 : 7'($urandom);
         end
         a = pick(); b = pick();
         x = ref_op(opc, f3, f7, a, b);
         issue(opc, f3, f7, a, b, rdy, lat, o, e, busy);
         total++; if ({lat, e, o} !== {32'd1, x}) begin bad++; $display("FAIL base%0d got lat=%0d err=%b out=%h exp lat=1 err=%b out=%h", i, lat, e, o, x[XLEN], x[XLEN-1:0]); end
      end
   endtask

   task automatic test_random_m();
      logic rdy, e, busy; int lat, el; logic [31:0] o, a, b; logic [2:0] f3; logic [XLEN:0] x;
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom);
         a = pick(); b = pick();
         x = ref_op(OPR, f3, 7'h01, a, b);
         el = ref_lat(OPR, f3, 7'h01, a, b);
         issue(OPR, f3, 7'h01, a, b, rdy, lat, o, e, busy);
         total++; if ({lat, e, o} !== {el, x}) begin bad++; $display("FAIL mop%0d f3=%0d got lat=%0d err=%b out=%h exp lat=%0d err=%b out=%h", i, f3, lat, e, o, el, x[XLEN], x[XLEN-1:0]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expq [$]; logic [31:0] a, b, ex; logic [2:0] f3;
      bus.out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         #1;
         if (i > 0) begin
            ex = expq.pop_front();
            total++; if ({bus.out_valid, bus.out} !== {1'b1, ex}) begin bad++; $display("FAIL b2b%0d got valid=%b out=%h exp valid=1 out=%h", i - 1, bus.out_valid, bus.out, ex); end
            $display("txn b2b%0d out=%h", i - 1, bus.out);
         end
         if (i < 8) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, bus.in_ready); end
            f3 = 3'($urandom); a = 32'($urandom); b = 32'($urandom);
            ex = 32'(ref_op(OPR, f3, 7'h00, a, b));
            expq.push_back(ex);
            bus.opcode = OPR; bus.funct3 = f3; bus.funct7 = 7'h00; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
         end else bus.in_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      logic rdy, e, busy; int lat; logic [31:0] o;
      offer(OPR, 3'd5, 7'h01, 32'd100, 32'd7, 1'b0, rdy);
      wait_result(lat, o, e, busy);
      $display("txn divu a=100 b=7 out=%h lat=%0d", o, lat);
      total++; if ({lat, o} !== {32'd33, 32'd14}) begin bad++; $display("FAIL divu got lat=%0d out=%h exp lat=33 out=e", lat, o); end
      bus.opcode = OPR; bus.funct3 = 3'd0; bus.funct7 = 7'h00; bus.in1 = 32'd1; bus.in2 = 32'd1; bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if ({bus.out_valid, bus.out, bus.err, bus.in_ready} !== {1'b1, 32'd14, 1'b0, 1'b0}) begin bad++; $display("FAIL stall%0d got valid=%b out=%h err=%b ready=%b exp 1 e 0 0", i, bus.out_valid, bus.out, bus.err, bus.in_ready); end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", bus.in_ready); end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drained got valid=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_kill_reset();
      logic rdy, e, busy; int lat, seen; logic [31:0] o;
      seen = 0;
      offer(OPR, 3'd4, 7'h01, 32'd1000, 32'd3, 1'b1, rdy);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      bus.kill = 1'b1;
      @(posedge clk);
      #1 bus.kill = 1'b0;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL kill_idle in_ready got=%b exp=1", bus.in_ready); end
      @(negedge clk);
      bus.kill = 1'b1; bus.opcode = OPR; bus.funct3 = 3'd0; bus.funct7 = 7'h00; bus.in1 = 32'd1; bus.in2 = 32'd1; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.kill = 1'b0; bus.in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      $display("txn kill div and kill-vs-accept valid_seen=%0d", seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL kill got valid_cycles=%0d exp=0", seen); end
      seen = 0;
      offer(OPR, 3'd0, 7'h01, 32'd12345, 32'd678, 1'b1, rdy);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if ({bus.out_valid, bus.in_ready, bus.out} !== {1'b0, 1'b1, 32'h0}) begin bad++; $display("FAIL mid_reset got valid=%b ready=%b out=%h exp 0 1 0", bus.out_valid, bus.in_ready, bus.out); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      $display("txn reset mid mul valid_seen=%0d", seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL reset_discard got valid_cycles=%0d exp=0", seen); end
      issue(OPR, 3'd0, 7'h00, 32'd2, 32'd3, rdy, lat, o, e, busy);
      total++; if ({lat, o, e} !== {32'd1, 32'd5, 1'b0}) begin bad++; $display("FAIL add_after got lat=%0d out=%h err=%b exp lat=1 out=5 err=0", lat, o, e); end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_illegal();
      test_random_base();
      test_random_m();
      test_back_to_back();
      test_stall();
      test_kill_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
